// File: rtl/st_pkg.sv
// Shared types and constants for the register-list PUSH/POP sequencer.
package st_pkg;

  localparam int RL_W      = 9;
  localparam int LR_PC_BIT = 8;
  localparam int GPR_COUNT = 8;

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    WB,
    DONE
  } state_t;

endpackage

// File: rtl/st_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module st_prio_enc #(
  parameter int W  = st_pkg::RL_W,
  parameter int SW = $clog2(W)
) (
  input  logic [W-1:0]  vec,
  output logic [SW-1:0] sel,
  output logic          valid
);

  always_comb begin
    sel   = '0;
    valid = 1'b0;
    // Scan downward so the lowest set bit is the one left in sel.
    for (int i = W - 1; i >= 0; i--) begin
      if (vec[i]) begin
        sel   = SW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/st_multi_seq.sv
// Multi-cycle PUSH/POP sequencer: walks a register list one entry per cycle,
// drives data memory and register-file controls, then writes back SP.
module st_multi_seq #(
  parameter int ADDR_W = 16,
  parameter int RL_W   = st_pkg::RL_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_push,
  input  logic [RL_W-1:0]   RL,
  input  logic [ADDR_W-1:0] sp_in,
  output logic              busy,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_wr,
  output logic              dmem_rd,
  output logic [2:0]        rsrc_addr,
  output logic              lr_sel,
  output logic [2:0]        rdest_addr,
  output logic              RF_wr,
  output logic              PC_wr,
  output logic              sp_wr,
  output logic [ADDR_W-1:0] sp_next,
  output logic              done
);

  import st_pkg::*;

  localparam int SEL_BITS = $clog2(RL_W);

  state_t              state_reg, state_next;
  logic [RL_W-1:0]     mask_reg, mask_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W-1:0]   sp_final_reg, sp_final_next;
  logic                push_reg, push_next;
  logic                spwr_en_reg, spwr_en_next;
  logic                pipe_valid_reg, pipe_valid_next;
  logic [SEL_BITS-1:0] pipe_sel_reg, pipe_sel_next;

  logic [SEL_BITS-1:0] sel;
  logic                sel_valid;
  logic [ADDR_W-1:0]   n_count;
  logic [ADDR_W-1:0]   base;

  st_prio_enc #(.W(RL_W), .SW(SEL_BITS)) u_enc (
    .vec   (mask_reg),
    .sel   (sel),
    .valid (sel_valid)
  );

  always_comb begin
    n_count = '0;
    for (int i = 0; i < RL_W; i++) begin
      n_count = n_count + ADDR_W'(RL[i]);
    end
    base = is_push ? (sp_in - n_count) : sp_in;
  end

  always_comb begin
    state_next      = state_reg;
    mask_next       = mask_reg;
    addr_next       = addr_reg;
    sp_final_next   = sp_final_reg;
    push_next       = push_reg;
    spwr_en_next    = spwr_en_reg;
    pipe_valid_next = 1'b0;
    pipe_sel_next   = pipe_sel_reg;
    busy       = 1'b0;
    dmem_addr  = '0;
    dmem_wr    = 1'b0;
    dmem_rd    = 1'b0;
    rsrc_addr  = '0;
    lr_sel     = 1'b0;
    rdest_addr = '0;
    RF_wr      = 1'b0;
    PC_wr      = 1'b0;
    sp_wr      = 1'b0;
    sp_next    = '0;
    done       = 1'b0;

    // POP data lands one cycle after its read; the pipe is only live in XFER/WB.
    if (pipe_valid_reg) begin
      if (pipe_sel_reg == SEL_BITS'(LR_PC_BIT)) begin
        PC_wr = 1'b1;
      end else begin
        RF_wr      = 1'b1;
        rdest_addr = pipe_sel_reg[2:0];
      end
    end

    case (state_reg)
      IDLE: begin
        if (start) begin
          mask_next = RL;
          push_next = is_push;
          addr_next = base;
          sp_final_next = is_push ? base : (sp_in + n_count);
          if (n_count == '0) begin
            spwr_en_next = 1'b0;
            state_next   = DONE;
          end else begin
            spwr_en_next = 1'b1;
            state_next   = XFER;
          end
        end
      end
      XFER: begin
        busy = 1'b1;
        if (sel_valid) begin
          dmem_addr = addr_reg;
          addr_next = addr_reg + ADDR_W'(1);
          mask_next = mask_reg & ~(RL_W'(1) << sel);
          if (push_reg) begin
            dmem_wr = 1'b1;
            if (sel == SEL_BITS'(LR_PC_BIT)) lr_sel = 1'b1;
            else                             rsrc_addr = sel[2:0];
          end else begin
            dmem_rd         = 1'b1;
            pipe_valid_next = 1'b1;
            pipe_sel_next   = sel;
          end
        end
        if (mask_next == '0) begin
          state_next = push_reg ? DONE : WB;
        end
      end
      WB: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy = 1'b1;
        done = 1'b1;
        if (spwr_en_reg) begin
          sp_wr   = 1'b1;
          sp_next = sp_final_reg;
        end
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      mask_reg       <= '0;
      addr_reg       <= '0;
      sp_final_reg   <= '0;
      push_reg       <= 1'b0;
      spwr_en_reg    <= 1'b0;
      pipe_valid_reg <= 1'b0;
      pipe_sel_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      mask_reg       <= mask_next;
      addr_reg       <= addr_next;
      sp_final_reg   <= sp_final_next;
      push_reg       <= push_next;
      spwr_en_reg    <= spwr_en_next;
      pipe_valid_reg <= pipe_valid_next;
      pipe_sel_reg   <= pipe_sel_next;
    end
  end

endmodule

// File: tb/tb_st_multi_seq.sv
// Self-checking bench for st_multi_seq: per-cycle model compare plus literal checks.
module tb_st_multi_seq;

  typedef struct packed {
    logic        busy;
    logic [15:0] addr;
    logic        wr;
    logic        rd;
    logic [2:0]  rsrc;
    logic        lr;
    logic [2:0]  rdest;
    logic        rfwr;
    logic        pcwr;
    logic        spwr;
    logic [15:0] spn;
    logic        done;
  } outv_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_push;
  logic [8:0]  RL;
  logic [15:0] sp_in;
  logic        busy, dmem_wr, dmem_rd, lr_sel, RF_wr, PC_wr, sp_wr, done;
  logic [15:0] dmem_addr, sp_next;
  logic [2:0]  rsrc_addr, rdest_addr;

  st_multi_seq #(.ADDR_W(16), .RL_W(9)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .is_push    (is_push),
    .RL         (RL),
    .sp_in      (sp_in),
    .busy       (busy),
    .dmem_addr  (dmem_addr),
    .dmem_wr    (dmem_wr),
    .dmem_rd    (dmem_rd),
    .rsrc_addr  (rsrc_addr),
    .lr_sel     (lr_sel),
    .rdest_addr (rdest_addr),
    .RF_wr      (RF_wr),
    .PC_wr      (PC_wr),
    .sp_wr      (sp_wr),
    .sp_next    (sp_next),
    .done       (done)
  );

  always #5 clk = ~clk;

  outv_t act;
  assign act = {busy, dmem_addr, dmem_wr, dmem_rd, rsrc_addr, lr_sel,
                rdest_addr, RF_wr, PC_wr, sp_wr, sp_next, done};

  int    n_checks = 0;
  int    n_fail   = 0;
  outv_t exp_q[$];
  bit    checking = 1'b0;
  bit    idle_now = 1'b1;
  outv_t cap[16];
  int    cyc_idx  = 16;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Expected cycle-by-cycle outputs from the list semantics.
  task automatic model_start(input bit push, input logic [8:0] rl, input logic [15:0] sp);
    int          regs[$];
    int          n;
    outv_t       e;
    logic [15:0] base;
    for (int i = 0; i < 9; i++) if (rl[i]) regs.push_back(i);
    n = regs.size();
    if (n == 0) begin
      e = '0; e.busy = 1; e.done = 1; exp_q.push_back(e);
    end else if (push) begin
      base = sp - 16'(n);
      for (int k = 0; k < n; k++) begin
        e = '0; e.busy = 1; e.wr = 1; e.addr = base + 16'(k);
        if (regs[k] == 8) e.lr = 1; else e.rsrc = 3'(regs[k]);
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1; e.done = 1; e.spwr = 1; e.spn = base; exp_q.push_back(e);
    end else begin
      for (int k = 0; k <= n; k++) begin
        e = '0; e.busy = 1;
        if (k < n) begin e.rd = 1; e.addr = sp + 16'(k); end
        if (k > 0) begin
          if (regs[k-1] == 8) e.pcwr = 1;
          else begin e.rfwr = 1; e.rdest = 3'(regs[k-1]); end
        end
        exp_q.push_back(e);
      end
      e = '0; e.busy = 1; e.done = 1; e.spwr = 1; e.spn = sp + 16'(n); exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    outv_t e;
    if (checking) begin
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        idle_now = 1'b0;
      end else begin
        e = '0;
        idle_now = 1'b1;
      end
      n_checks++;
      if (act !== e) begin
        n_fail++;
        $display("FAIL cycle_model @%0t: got %h, required %h", $time, act, e);
      end
      if (cyc_idx < 16) begin
        cap[cyc_idx] = act;
        cyc_idx++;
      end
    end
  end

  task automatic begin_op(input bit push, input logic [8:0] rl, input logic [15:0] sp);
    @(negedge clk); #1;
    for (int i = 0; i < 16; i++) cap[i] = '0;
    start = 1'b1; is_push = push; RL = rl; sp_in = sp;
    if (idle_now) model_start(push, rl, sp);
    cyc_idx = 1;
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_op(input bit push, input logic [8:0] rl, input logic [15:0] sp);
    begin_op(push, rl, sp);
    repeat (14) @(negedge clk);
    $display("op %s RL=%h sp=%h complete", push ? "PUSH" : "POP", rl, sp);
  endtask

  function automatic int count_rd();
    int c = 0;
    for (int i = 1; i < 16; i++) if (cap[i].rd) c++;
    return c;
  endfunction

  function automatic int count_done();
    int c = 0;
    for (int i = 1; i < 16; i++) if (cap[i].done) c++;
    return c;
  endfunction

  function automatic int count_spwr();
    int c = 0;
    for (int i = 1; i < 16; i++) if (cap[i].spwr) c++;
    return c;
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; is_push = 1'b0; RL = '0; sp_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", 32'(act == '0), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    checking = 1'b1;
    repeat (2) @(negedge clk);

    run_op(1'b1, 9'h00B, 16'h0100);
    chk("push_c1_addr", 32'(cap[1].addr), 32'h00FD);
    chk("push_c1_wr_r0", 32'({cap[1].wr, cap[1].rsrc}), 32'h8);
    chk("push_c2_addr", 32'(cap[2].addr), 32'h00FE);
    chk("push_c3_r3", 32'({cap[3].wr, cap[3].rsrc, cap[3].addr}), 32'hB_00FF);
    chk("push_c4_sp", 32'({cap[4].spwr, cap[4].done, cap[4].spn}), 32'h3_00FD);

    run_op(1'b0, 9'h101, 16'h00FD);
    chk("pop_c1_rd", 32'({cap[1].rd, cap[1].addr}), 32'h1_00FD);
    chk("pop_c2_rd", 32'({cap[2].rd, cap[2].addr}), 32'h1_00FE);
    chk("pop_c2_rf", 32'({cap[2].rfwr, cap[2].rdest}), 32'h8);
    chk("pop_c3_pc", 32'({cap[3].pcwr, cap[3].rfwr}), 32'h2);
    chk("pop_c4_sp", 32'({cap[4].spwr, cap[4].done, cap[4].spn}), 32'h3_00FF);

    run_op(1'b1, 9'h100, 16'h0000);
    chk("lr_c1", 32'({cap[1].lr, cap[1].addr}), 32'h1_FFFF);
    chk("lr_sp_wrap", 32'(cap[2].spn), 32'hFFFF);

    run_op(1'b0, 9'h000, 16'h1234);
    chk("empty_done_c1", 32'({cap[1].done, cap[1].spwr}), 32'h2);
    chk("empty_no_spwr", 32'(count_spwr()), 32'd0);
    chk("empty_no_rd", 32'(count_rd()), 32'd0);

    run_op(1'b1, 9'h0F0, 16'h0010);
    run_op(1'b0, 9'h1FF, 16'hFFFC);

    // Full PUSH aborted by reset during cycle 4.
    begin_op(1'b1, 9'h1FF, 16'h0300);
    repeat (3) @(negedge clk);
    #1 reset = 1'b1;
    exp_q.delete();
    @(negedge clk); #1 reset = 1'b0;
    repeat (10) @(negedge clk);
    $display("op PUSH RL=1ff sp=0300 aborted by reset");
    chk("abort_c4_wr", 32'({cap[4].wr, cap[4].addr}), 32'h1_02FA);
    chk("abort_c5_idle", 32'(cap[5] == '0), 32'd1);
    chk("abort_no_spwr", 32'(count_spwr()), 32'd0);

    run_op(1'b1, 9'h003, 16'h0020);
    chk("after_reset_sp", 32'(cap[3].spn), 32'h001E);

    // start re-pulsed during a 3-register POP must be ignored.
    begin_op(1'b0, 9'h007, 16'h0200);
    #1 start = 1'b1; is_push = 1'b1; RL = 9'h1FF;
    @(negedge clk); #1 start = 1'b0;
    repeat (12) @(negedge clk);
    $display("op POP RL=007 sp=0200 with ignored restart complete");
    chk("restart_reads", 32'(count_rd()), 32'd3);
    chk("restart_done", 32'(count_done()), 32'd1);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
